// File: rtl/clock_pkg.sv
// Shared types and constants for the clock datapath counters.
//   BCD_W     : width of one BCD digit
//   bcd_t     : one BCD digit
//   *_MOD     : moduli of the standard clock stages
//   MONTH_MIN : months count from 1
//   bcd_value : binary value of a two-digit BCD pair (digits assumed <= 9)
package clock_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam int unsigned SEC_MOD   = 60;
  localparam int unsigned MIN_MOD   = 60;
  localparam int unsigned HOUR_MOD  = 24;
  localparam int unsigned MONTH_MOD = 12;
  localparam int unsigned MONTH_MIN = 1;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic logic [7:0] bcd_value(input bcd_t ten, input bcd_t unit);
    return ({4'd0, ten} * 8'd10) + {4'd0, unit};
  endfunction

endpackage

// File: rtl/pulse_rise.sv
// 1-bit rising-edge detector.
//   clk_i : clock
//   rst_i : asynchronous active-high reset, clears the history register
//   d_i   : level input
//   p_o   : high for the cycle where d_i is 1 and was 0 on the previous edge
module pulse_rise (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic p_o
);

  logic d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign p_o = d_i & ~d_q;

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter, one building block for sec/min/hour/day/month.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   run_i                  : 1 = count tick_in_i, 0 = set mode (up_i/down_i adjust)
//   tick_in_i              : count enable / carry from the previous stage
//   up_i, down_i           : set-mode adjust requests
//   load_i, load_ten_i,
//   load_unit_i            : direct load of a BCD value (any mode, highest priority)
//   ten_o, unit_o          : registered BCD count
//   tick_out_o             : registered carry pulse, coincident with the wrapped value
//   at_max_o               : registered, high while the count equals the maximum
//   load_err_o             : one-cycle pulse when a load value is rejected
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS   = SEC_MOD,
  parameter int unsigned MIN_VALUE = 0,
  parameter int unsigned EDGE_STEP = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  input  logic       tick_in_i,
  input  logic       up_i,
  input  logic       down_i,
  input  logic       load_i,
  input  logic [3:0] load_unit_i,
  input  logic [3:0] load_ten_i,
  output logic [3:0] unit_o,
  output logic [3:0] ten_o,
  output logic       tick_out_o,
  output logic       at_max_o,
  output logic       load_err_o
);

  localparam int unsigned MaxValue = MIN_VALUE + MODULUS - 1;
  localparam bcd_t MinTen  = bcd_t'(MIN_VALUE / 10);
  localparam bcd_t MinUnit = bcd_t'(MIN_VALUE % 10);
  localparam bcd_t MaxTen  = bcd_t'(MaxValue / 10);
  localparam bcd_t MaxUnit = bcd_t'(MaxValue % 10);

  bcd_t ten_q, ten_d, unit_q, unit_d;
  logic tick_out_q, tick_out_d;
  logic at_max_q, at_max_d;
  logic load_err_q, load_err_d;

  // Edge history runs every cycle regardless of mode, so a button already held
  // when set mode is entered does not produce a step.
  logic up_rise, down_rise;

  pulse_rise u_up_rise (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (up_i),
    .p_o   (up_rise)
  );

  pulse_rise u_down_rise (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (down_i),
    .p_o   (down_rise)
  );

  logic up_evt, down_evt, step_up, step_down;

  assign up_evt   = (EDGE_STEP != 0) ? up_rise   : up_i;
  assign down_evt = (EDGE_STEP != 0) ? down_rise : down_i;
  // Both levels high is a hold, even on the cycle one of them rises.
  assign step_up   = ~run_i & up_evt   & ~down_i;
  assign step_down = ~run_i & down_evt & ~up_i;

  logic cnt_at_max, cnt_at_min;

  assign cnt_at_max = (ten_q == MaxTen) && (unit_q == MaxUnit);
  assign cnt_at_min = (ten_q == MinTen) && (unit_q == MinUnit);

  // Increment / decrement candidates.
  bcd_t inc_ten, inc_unit, dec_ten, dec_unit;

  always_comb begin
    inc_ten  = ten_q;
    inc_unit = unit_q + 4'd1;
    if (cnt_at_max) begin
      inc_ten  = MinTen;
      inc_unit = MinUnit;
    end else if (unit_q == 4'd9) begin
      inc_ten  = ten_q + 4'd1;
      inc_unit = 4'd0;
    end

    dec_ten  = ten_q;
    dec_unit = unit_q - 4'd1;
    if (cnt_at_min) begin
      dec_ten  = MaxTen;
      dec_unit = MaxUnit;
    end else if (unit_q == 4'd0) begin
      dec_ten  = ten_q - 4'd1;
      dec_unit = 4'd9;
    end
  end

  // Load validation: BCD digits and within [MIN_VALUE, MaxValue].
  logic [7:0] load_val;
  logic       load_ok;

  assign load_val = bcd_value(load_ten_i, load_unit_i);
  // The +1 form keeps the lower-bound test non-constant when MIN_VALUE is 0.
  assign load_ok  = (load_ten_i <= 4'd9) && (load_unit_i <= 4'd9) &&
                    ((9'(load_val) + 9'd1) > 9'(MIN_VALUE)) &&
                    (load_val <= 8'(MaxValue));

  always_comb begin
    ten_d      = ten_q;
    unit_d     = unit_q;
    tick_out_d = 1'b0;
    load_err_d = 1'b0;
    if (load_i) begin
      if (load_ok) begin
        ten_d  = load_ten_i;
        unit_d = load_unit_i;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (run_i) begin
      if (tick_in_i) begin
        ten_d      = inc_ten;
        unit_d     = inc_unit;
        tick_out_d = cnt_at_max;
      end
    end else if (step_up) begin
      ten_d  = inc_ten;
      unit_d = inc_unit;
    end else if (step_down) begin
      ten_d  = dec_ten;
      unit_d = dec_unit;
    end
    at_max_d = (ten_d == MaxTen) && (unit_d == MaxUnit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ten_q      <= MinTen;
      unit_q     <= MinUnit;
      tick_out_q <= 1'b0;
      at_max_q   <= (MinTen == MaxTen) && (MinUnit == MaxUnit);
      load_err_q <= 1'b0;
    end else begin
      ten_q      <= ten_d;
      unit_q     <= unit_d;
      tick_out_q <= tick_out_d;
      at_max_q   <= at_max_d;
      load_err_q <= load_err_d;
    end
  end

  assign ten_o      = ten_q;
  assign unit_o     = unit_q;
  assign tick_out_o = tick_out_q;
  assign at_max_o   = at_max_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_bcd_mod_counter.sv
module tb_bcd_mod_counter;
  import clock_pkg::*;

  logic       clk;
  logic       rst;
  logic       run, tick_in, up, down, load;
  logic [3:0] load_unit, load_ten;

  logic [3:0] ten_w  [4];
  logic [3:0] unit_w [4];
  logic       tick_w [4];
  logic       atm_w  [4];
  logic       err_w  [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    dut;
    int    val;
    bit    tick;
    bit    err;
    string name;
  } exp_t;

  exp_t sb[$];

  // 0: 60/0/edge, 1: 60/0/level, 2: 24/0/level, 3: 12/1/edge
  bcd_mod_counter #(.MODULUS(SEC_MOD), .MIN_VALUE(0), .EDGE_STEP(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .run_i(run), .tick_in_i(tick_in), .up_i(up), .down_i(down),
    .load_i(load), .load_unit_i(load_unit), .load_ten_i(load_ten),
    .unit_o(unit_w[0]), .ten_o(ten_w[0]), .tick_out_o(tick_w[0]), .at_max_o(atm_w[0]),
    .load_err_o(err_w[0]));

  bcd_mod_counter #(.MODULUS(MIN_MOD), .MIN_VALUE(0), .EDGE_STEP(0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .run_i(run), .tick_in_i(tick_in), .up_i(up), .down_i(down),
    .load_i(load), .load_unit_i(load_unit), .load_ten_i(load_ten),
    .unit_o(unit_w[1]), .ten_o(ten_w[1]), .tick_out_o(tick_w[1]), .at_max_o(atm_w[1]),
    .load_err_o(err_w[1]));

  bcd_mod_counter #(.MODULUS(HOUR_MOD), .MIN_VALUE(0), .EDGE_STEP(0)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .run_i(run), .tick_in_i(tick_in), .up_i(up), .down_i(down),
    .load_i(load), .load_unit_i(load_unit), .load_ten_i(load_ten),
    .unit_o(unit_w[2]), .ten_o(ten_w[2]), .tick_out_o(tick_w[2]), .at_max_o(atm_w[2]),
    .load_err_o(err_w[2]));

  bcd_mod_counter #(.MODULUS(MONTH_MOD), .MIN_VALUE(MONTH_MIN), .EDGE_STEP(1)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .run_i(run), .tick_in_i(tick_in), .up_i(up), .down_i(down),
    .load_i(load), .load_unit_i(load_unit), .load_ten_i(load_ten),
    .unit_o(unit_w[3]), .ten_o(ten_w[3]), .tick_out_o(tick_w[3]), .at_max_o(atm_w[3]),
    .load_err_o(err_w[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int max_of(input int d);
    case (d)
      2:       return 23;
      3:       return 12;
      default: return 59;
    endcase
  endfunction

  task automatic compare(input int d, input int v, input bit tk, input bit er, input string nm);
    logic [3:0] et, eu;
    bit         em;
    et = 4'(v / 10);
    eu = 4'(v % 10);
    em = (v == max_of(d));
    checks++;
    if (ten_w[d] !== et || unit_w[d] !== eu || tick_w[d] !== tk || atm_w[d] !== em ||
        err_w[d] !== er) begin
      errors++;
      $display("FAIL %s dut%0d: got ten=%0h unit=%0h tick=%b at_max=%b err=%b, want %0h%0h %b %b %b",
               nm, d, ten_w[d], unit_w[d], tick_w[d], atm_w[d], err_w[d], et, eu, tk, em, er);
    end
  endtask

  // Monitor: each clocked step leaves one expectation, checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        compare(e.dut, e.val, e.tick, e.err, e.name);
      end
    end
  end

  // Inputs are already driven; queue the expected response and advance one cycle.
  task automatic step(input int d, input int v, input bit tk, input bit er, input string nm);
    exp_t e;
    e.dut  = d;
    e.val  = v;
    e.tick = tk;
    e.err  = er;
    e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    run = 0; tick_in = 0; up = 0; down = 0; load = 0; load_unit = 0; load_ten = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    #1;
    rst = 0;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] u);
    load = 1; load_ten = t; load_unit = u;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    compare(0, 0, 0, 0, "reset_60");
    compare(2, 0, 0, 0, "reset_24");
    compare(3, 1, 0, 0, "reset_min1");
    rst = 0;

    // Asynchronous reset mid-count at 37.
    do_load(4'd3, 4'd7);
    step(0, 37, 0, 0, "load_37");
    load = 0;
    #2 rst = 1;
    #1;
    compare(0, 0, 0, 0, "async_rst_60");
    compare(3, 1, 0, 0, "async_rst_min1");
    @(negedge clk);
    #1;
    rst = 0;

    // Run mode: full cycle with one carry on the wrap.
    do_reset();
    run = 1; tick_in = 1;
    for (int i = 1; i <= 60; i++) step(0, i % 60, (i == 60), 0, "run_count");
    tick_in = 0;
    repeat (3) step(0, 0, 0, 0, "run_hold");
    tick_in = 1;
    step(0, 1, 0, 0, "run_after_wrap");
    run = 0;
    step(0, 1, 0, 0, "switch_to_set");

    // Set mode, edge stepping; tick_in is ignored here.
    do_reset();
    tick_in = 1; up = 1; down = 1;
    repeat (65) step(0, 0, 0, 0, "set_both_hold");
    up = 0; down = 0;
    step(0, 0, 0, 0, "set_release");
    up = 1;
    step(0, 1, 0, 0, "set_up_edge");
    repeat (64) step(0, 1, 0, 0, "set_up_held");
    up = 0;
    step(0, 1, 0, 0, "set_up_release");
    down = 1;
    step(0, 0, 0, 0, "set_down_1");
    down = 0;
    step(0, 0, 0, 0, "set_down_rel");
    down = 1;
    step(0, 59, 0, 0, "set_down_wrap");
    down = 0;
    step(0, 59, 0, 0, "set_down_rel2");
    run = 1; tick_in = 0; up = 1;
    step(0, 59, 0, 0, "run_ignores_up");
    run = 0;
    step(0, 59, 0, 0, "enter_set_up_high");
    up = 0;
    step(0, 59, 0, 0, "set_idle");

    // Set mode, level stepping.
    do_reset();
    up = 1;
    for (int i = 1; i <= 65; i++) step(1, i % 60, 0, 0, "level_up");
    up = 0;
    do_reset();
    down = 1;
    step(2, 23, 0, 0, "hour_down_wrap");
    step(2, 22, 0, 0, "hour_down");
    down = 0;

    // Month counter, MIN_VALUE = 1.
    do_reset();
    compare(3, 1, 0, 0, "month_reset");
    do_load(4'd1, 4'd2);
    step(3, 12, 0, 0, "month_load_12");
    load = 0; run = 1; tick_in = 1;
    step(3, 1, 1, 0, "month_wrap");
    tick_in = 0;
    step(3, 1, 0, 0, "month_hold");
    do_load(4'd0, 4'd0);
    step(3, 1, 0, 1, "month_load_00");
    load = 0;
    step(3, 1, 0, 0, "month_err_clear");

    // Loads on the 60-counter.
    do_reset();
    do_load(4'd4, 4'd7);
    step(0, 47, 0, 0, "load_47");
    do_load(4'd6, 4'd0);
    step(0, 47, 0, 1, "load_60_bad");
    do_load(4'd3, 4'hA);
    step(0, 47, 0, 1, "load_3A_bad");
    do_load(4'd5, 4'd9);
    step(0, 59, 0, 0, "load_59");
    do_load(4'd1, 4'd2);
    run = 1; tick_in = 1;
    step(0, 12, 0, 0, "load_beats_tick");
    load = 0; tick_in = 0;
    step(0, 12, 0, 0, "load_hold");

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
